// File: rtl/cmac_block_loader.sv
// Byte-stream to 128-bit word loader for the AES-CMAC message BRAM.
// Packs bytes big-endian, applies 10* padding to a final partial block,
// and reports the message length in bits.
module cmac_block_loader #(
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned MAX_BLOCKS = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [127:0]      wr_data,
    output logic [31:0]       len,
    output logic              load_done,
    output logic              overflow
);

    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned WORD_W = 128;
    localparam int unsigned LANES  = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BLOCKS);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t             state_q;
    state_t             state_n;
    logic [3:0]         idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WORD_W-1:0]  word_q;
    logic               last_q;

    logic               accept_c;
    logic               blk_end_c;
    logic               at_max_c;
    logic [WORD_W-1:0]  packed_c;

    // Handshake and block-completion decode
    assign s_ready   = (state_q == FILL) & ~start;
    assign accept_c  = s_valid & s_ready;
    assign blk_end_c = accept_c & ((idx_q == 4'd15) | s_last);
    assign at_max_c  = (cnt_q == CNT_MAX);

    // Word with the incoming byte inserted; on s_last the next lane gets the 0x80 pad marker.
    // Lanes above that are already zero because word_q is cleared at every block boundary.
    always_comb begin
        packed_c = word_q;
        for (int i = 0; i < int'(LANES); i++) begin
            if (idx_q == 4'(i)) begin
                packed_c[8*(15-i) +: 8] = s_data;
            end else if (s_last && (int'(idx_q) + 1 == i)) begin
                packed_c[8*(15-i) +: 8] = 8'h80;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state_q;
        if (start) begin
            state_n = FILL;
        end else begin
            unique case (state_q)
                IDLE:    state_n = IDLE;
                FILL:    if (blk_end_c) state_n = WRITE;
                WRITE: begin
                    if (at_max_c)    state_n = ERR;
                    else if (last_q) state_n = DONE;
                    else             state_n = FILL;
                end
                DONE:    state_n = DONE;
                ERR:     state_n = ERR;
                default: state_n = IDLE;
            endcase
        end
    end

    // Datapath, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q     <= 4'd0;
            cnt_q     <= '0;
            word_q    <= '0;
            last_q    <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            len       <= 32'd0;
            load_done <= 1'b0;
            overflow  <= 1'b0;
        end else if (start) begin
            idx_q     <= 4'd0;
            cnt_q     <= '0;
            word_q    <= '0;
            last_q    <= 1'b0;
            wr_en     <= 1'b0;
            len       <= 32'd0;
            load_done <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            unique case (state_q)
                FILL: begin
                    if (accept_c) begin
                        len <= len + 32'd8;
                        if (blk_end_c) begin
                            // Write is presented during the WRITE cycle; suppressed when the BRAM is full
                            wr_en   <= ~at_max_c;
                            wr_addr <= cnt_q[ADDR_W-1:0];
                            wr_data <= packed_c;
                            word_q  <= '0;
                            idx_q   <= 4'd0;
                            last_q  <= s_last;
                        end else begin
                            word_q <= packed_c;
                            idx_q  <= idx_q + 4'd1;
                        end
                    end
                end
                WRITE: begin
                    if (at_max_c) begin
                        overflow <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (last_q) load_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cmac_block_loader.sv
// Scoreboard bench for cmac_block_loader: expected BRAM writes are queued
// when a message is driven and compared as the DUT issues them.
module tb_cmac_block_loader;

    typedef struct packed {
        logic [8:0]   addr;
        logic [127:0] data;
    } wr_t;

    typedef logic [7:0] bq_t[$];

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         s_valid;
    logic [7:0]   s_data;
    logic         s_last;

    logic         s_ready, wr_en, load_done, overflow;
    logic [8:0]   wr_addr;
    logic [127:0] wr_data;
    logic [31:0]  len;

    logic         s_ready2, wr_en2, load_done2, overflow2;
    logic [8:0]   wr_addr2;
    logic [127:0] wr_data2;
    logic [31:0]  len2;

    int checks = 0;
    int errors = 0;

    wr_t exp_q[$];
    wr_t exp2_q[$];
    wr_t e_m, e_m2;
    logic prev_we = 1'b0;
    logic prev_we2 = 1'b0;

    cmac_block_loader #(.ADDR_W(9), .MAX_BLOCKS(512)) dut (
        .clk(clk), .reset(reset), .start(start),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .len(len), .load_done(load_done), .overflow(overflow)
    );

    cmac_block_loader #(.ADDR_W(9), .MAX_BLOCKS(2)) dut2 (
        .clk(clk), .reset(reset), .start(start),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready2),
        .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .len(len2), .load_done(load_done2), .overflow(overflow2)
    );

    always #5 clk = ~clk;

    // Scoreboard for the full-size instance; also flags back-to-back write strobes
    always @(negedge clk) begin
        if (reset) begin
            prev_we = 1'b0;
        end else begin
            if (wr_en) begin
                checks++;
                if (prev_we) begin
                    errors++;
                    $display("FAIL wr_en_consecutive addr=%0d", wr_addr);
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr=%0d data=%h", wr_addr, wr_data);
                end else begin
                    e_m = exp_q.pop_front();
                    if (wr_addr !== e_m.addr || wr_data !== e_m.data) begin
                        errors++;
                        $display("FAIL write got addr=%0d data=%h expected addr=%0d data=%h",
                                 wr_addr, wr_data, e_m.addr, e_m.data);
                    end
                end
            end
            prev_we = wr_en;
        end
    end

    // Scoreboard for the two-block instance
    always @(negedge clk) begin
        if (reset) begin
            prev_we2 = 1'b0;
        end else begin
            if (wr_en2) begin
                checks++;
                if (prev_we2) begin
                    errors++;
                    $display("FAIL wr_en2_consecutive addr=%0d", wr_addr2);
                end else if (exp2_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write2 addr=%0d data=%h", wr_addr2, wr_data2);
                end else begin
                    e_m2 = exp2_q.pop_front();
                    if (wr_addr2 !== e_m2.addr || wr_data2 !== e_m2.data) begin
                        errors++;
                        $display("FAIL write2 got addr=%0d data=%h expected addr=%0d data=%h",
                                 wr_addr2, wr_data2, e_m2.addr, e_m2.data);
                    end
                end
            end
            prev_we2 = wr_en2;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, input int gap);
        logic rdy;
        int   n;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        rdy     = 1'b0;
        n       = 0;
        while (!rdy && n < 64) begin
            @(negedge clk);
            rdy = s_ready;
            @(posedge clk); #1;
            n++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        checks++;
        if (!rdy) begin
            errors++;
            $display("FAIL byte_accept_timeout data=%h", d);
        end
    endtask

    // Packs the message independently, queues expected writes, drives bytes, checks completion timing
    task automatic send_msg(input bq_t msg, input int max_gap, input string name);
        int n, nblk, j;
        logic [127:0] w;
        wr_t e;
        n    = msg.size();
        nblk = (n + 15) / 16;
        for (int b = 0; b < nblk; b++) begin
            w = '0;
            for (int k = 0; k < 16; k++) begin
                j = b * 16 + k;
                if (j < n)       w[127-8*k -: 8] = msg[j];
                else if (j == n) w[127-8*k -: 8] = 8'h80;
            end
            e.addr = 9'(b);
            e.data = w;
            exp_q.push_back(e);
            if (b < 2) exp2_q.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            send_byte(msg[i], (i == n - 1), (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        end
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b1 || load_done !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s write_cycle got wr_en=%b load_done=%b s_ready=%b expected 1 0 0",
                     name, wr_en, load_done, s_ready);
        end
        @(negedge clk);
        checks++;
        if (load_done !== 1'b1 || s_ready !== 1'b0 || wr_en !== 1'b0) begin
            errors++;
            $display("FAIL %s done got load_done=%b s_ready=%b wr_en=%b expected 1 0 0",
                     name, load_done, s_ready, wr_en);
        end
        checks++;
        if (len !== 32'(n * 8)) begin
            errors++;
            $display("FAIL %s len got %0d expected %0d", name, len, n * 8);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s writes_missing got %0d pending expected 0", name, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        checks++;
        if ({s_ready, wr_en, wr_addr, wr_data, len, load_done, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_values got s_ready=%b wr_en=%b addr=%0d data=%h len=%0d done=%b ovf=%b expected all 0",
                     s_ready, wr_en, wr_addr, wr_data, len, load_done, overflow);
        end
        reset = 1'b0;
        s_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b0 || len !== 32'd0) begin
            errors++;
            $display("FAIL idle_not_ready got s_ready=%b len=%0d expected 0 0", s_ready, len);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic test_full_block();
        bq_t m;
        for (int i = 0; i < 16; i++) m.push_back(8'(i));
        do_start();
        send_msg(m, 0, "full_block");
    endtask

    task automatic test_two_blocks();
        bq_t m;
        for (int i = 0; i < 17; i++) m.push_back(8'(i));
        do_start();
        send_msg(m, 0, "two_blocks");
    endtask

    task automatic test_stale_pad();
        bq_t m;
        m.push_back(8'hAA);
        m.push_back(8'hBB);
        m.push_back(8'hCC);
        do_start();
        send_msg(m, 0, "stale_pad");
    endtask

    task automatic test_overflow();
        bq_t m;
        for (int i = 0; i < 33; i++) m.push_back(8'(i + 8'h40));
        do_start();
        send_msg(m, 0, "overflow_main");
        checks++;
        if (overflow2 !== 1'b1 || load_done2 !== 1'b0 || s_ready2 !== 1'b0) begin
            errors++;
            $display("FAIL overflow_state got ovf=%b done=%b s_ready=%b expected 1 0 0",
                     overflow2, load_done2, s_ready2);
        end
        checks++;
        if (exp2_q.size() != 0) begin
            errors++;
            $display("FAIL overflow_writes_missing got %0d pending expected 0", exp2_q.size());
            exp2_q.delete();
        end
        s_valid = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (overflow2 !== 1'b1 || s_ready2 !== 1'b0) begin
            errors++;
            $display("FAIL overflow_hold got ovf=%b s_ready=%b expected 1 0", overflow2, s_ready2);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        do_start();
        @(negedge clk);
        checks++;
        if (overflow2 !== 1'b0 || s_ready2 !== 1'b1) begin
            errors++;
            $display("FAIL overflow_clear got ovf=%b s_ready=%b expected 0 1", overflow2, s_ready2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_gaps();
        bq_t m;
        for (int i = 0; i < 48; i++) m.push_back(8'($urandom_range(0, 255)));
        do_start();
        send_msg(m, 3, "random_gaps");
        exp2_q.delete();
    endtask

    task automatic test_async_reset();
        do_start();
        for (int i = 0; i < 7; i++) send_byte(8'(i + 8'h60), 1'b0, 0);
        checks++;
        if (len !== 32'd56) begin
            errors++;
            $display("FAIL pre_reset_len got %0d expected 56", len);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({s_ready, wr_en, wr_addr, wr_data, len, load_done, overflow} !== '0 ||
            {s_ready2, len2} !== '0) begin
            errors++;
            $display("FAIL async_reset got s_ready=%b wr_en=%b addr=%0d data=%h len=%0d done=%b ovf=%b expected all 0",
                     s_ready, wr_en, wr_addr, wr_data, len, load_done, overflow);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        s_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (s_ready !== 1'b0 || len !== 32'd0) begin
                errors++;
                $display("FAIL post_reset_idle got s_ready=%b len=%0d expected 0 0", s_ready, len);
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        begin
            bq_t m;
            for (int i = 0; i < 16; i++) m.push_back(8'(i + 8'h20));
            do_start();
            send_msg(m, 0, "after_reset");
        end
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        repeat (2) @(posedge clk); #1;
        test_reset();
        test_full_block();
        test_two_blocks();
        test_stale_pad();
        test_overflow();
        test_gaps();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
